// File: rtl/ex_alu_mdu.sv
// Execute stage: operand-B select, ALU with a registered result, and a
// multi-cycle multiply/divide unit that owns HI/LO and requests stalls.
module ex_alu_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] ext_imm,
  input  logic        alu_src,
  input  logic [3:0]  alu_op,
  input  logic [2:0]  md_op,
  input  logic [1:0]  res_sel,
  output logic [31:0] res_out,
  output logic        res_valid,
  output logic        busy,
  output logic        stall_out,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  state_dbg
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] counter;
  logic [63:0]   pending;

  logic [31:0] opb;
  logic [31:0] alu_res;
  logic [31:0] sel_val;
  logic [4:0]  shamt;
  logic        accept;
  logic        md_signed;
  logic        b_zero;

  assign opb       = alu_src ? ext_imm : rt_val;
  assign shamt     = rs_val[4:0];
  assign state_dbg = state;
  assign b_zero    = (opb == 32'd0);
  assign md_signed = (md_op == 3'd1) || (md_op == 3'd3);

  always_comb begin
    alu_res = 32'd0;
    case (alu_op)
      4'd0:    alu_res = rs_val + opb;
      4'd1:    alu_res = rs_val - opb;
      4'd2:    alu_res = rs_val & opb;
      4'd3:    alu_res = rs_val | opb;
      4'd4:    alu_res = rs_val ^ opb;
      4'd5:    alu_res = ~(rs_val | opb);
      4'd6:    alu_res = ($signed(rs_val) < $signed(opb)) ? 32'd1 : 32'd0;
      4'd7:    alu_res = (rs_val < opb) ? 32'd1 : 32'd0;
      4'd8:    alu_res = opb << shamt;
      4'd9:    alu_res = opb >> shamt;
      4'd10:   alu_res = $signed(opb) >>> shamt;
      4'd11:   alu_res = opb;
      default: alu_res = 32'd0;
    endcase
  end

  // Only MDU traffic and HI/LO reads wait for a busy MDU; plain ALU ops flow.
  assign stall_out = valid_in & busy &
                     ((md_op != 3'd0) | (res_sel == 2'd1) | (res_sel == 2'd2));
  assign accept    = valid_in & ~stall_out;

  always_comb begin
    sel_val = alu_res;
    case (res_sel)
      2'd1:    sel_val = hi;
      2'd2:    sel_val = lo;
      default: sel_val = alu_res;
    endcase
  end

  // One 64x64 multiplier on extended operands gives both signed and unsigned products.
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;

  assign mul_a   = md_signed ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
  assign mul_b   = md_signed ? {{32{opb[31]}}, opb} : {32'd0, opb};
  assign product = mul_a * mul_b;

  // Divide on magnitudes, then restore signs: quotient truncates toward zero
  // and the remainder follows the dividend.
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] uquot;
  logic [31:0] urem;
  logic [31:0] quot;
  logic [31:0] rem;

  assign a_neg = md_signed & rs_val[31];
  assign b_neg = md_signed & opb[31];
  assign a_mag = a_neg ? (32'd0 - rs_val) : rs_val;
  assign b_mag = b_neg ? (32'd0 - opb) : opb;
  assign uquot = b_zero ? 32'd0 : (a_mag / b_mag);
  assign urem  = b_zero ? 32'd0 : (a_mag % b_mag);
  assign quot  = (a_neg ^ b_neg) ? (32'd0 - uquot) : uquot;
  assign rem   = a_neg ? (32'd0 - urem) : urem;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_out   <= 32'd0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      state     <= S_IDLE;
      counter   <= '0;
      pending   <= 64'd0;
    end else begin
      res_valid <= accept;
      if (accept) begin
        res_out <= sel_val;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            case (md_op)
              3'd1, 3'd2: begin
                pending <= product;
                counter <= CW'(MULT_CYCLES);
                state   <= S_MUL;
                busy    <= 1'b1;
              end
              3'd3, 3'd4: begin
                if (!b_zero) begin
                  pending <= {rem, quot};
                  counter <= CW'(DIV_CYCLES);
                  state   <= S_DIV;
                  busy    <= 1'b1;
                end
              end
              3'd5:    hi <= rs_val;
              3'd6:    lo <= rs_val;
              default: ;
            endcase
          end
        end

        S_MUL, S_DIV: begin
          if (counter == CW'(1)) begin
            hi      <= pending[63:32];
            lo      <= pending[31:0];
            busy    <= 1'b0;
            counter <= '0;
            state   <= S_IDLE;
          end else begin
            counter <= counter - CW'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_alu_mdu.sv
// Bench for ex_alu_mdu: directed scenarios plus random traffic, all checked
// against a cycle-level reference model built from plain integer arithmetic.
module tb_ex_alu_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset_n;
  logic        valid_in;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] ext_imm;
  logic        alu_src;
  logic [3:0]  alu_op;
  logic [2:0]  md_op;
  logic [1:0]  res_sel;
  logic [31:0] res_out;
  logic        res_valid;
  logic        busy;
  logic        stall_out;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  state_dbg;

  ex_alu_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .valid_in  (valid_in),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .ext_imm   (ext_imm),
    .alu_src   (alu_src),
    .alu_op    (alu_op),
    .md_op     (md_op),
    .res_sel   (res_sel),
    .res_out   (res_out),
    .res_valid (res_valid),
    .busy      (busy),
    .stall_out (stall_out),
    .hi        (hi),
    .lo        (lo),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // reference model state
  logic [31:0] m_hi, m_lo, m_res, m_phi, m_plo;
  logic        m_rv;
  int          m_rem;
  logic        obs_stall;

  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_res = 0; m_rv = 0; m_rem = 0; m_phi = 0; m_plo = 0;
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    int sb;
    sh = int'(a % 32);
    sb = int'(b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a | b);
      4'd6:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd7:    return (a < b) ? 32'd1 : 32'd0;
      4'd8:    return b << sh;
      4'd9:    return b >> sh;
      4'd10:   return 32'(sb >>> sh);
      4'd11:   return b;
      default: return 32'd0;
    endcase
  endfunction

  // driver tasks
  task automatic drv(input logic v, input logic [31:0] a, input logic [31:0] rt,
                     input logic [31:0] imm, input logic src, input logic [3:0] op,
                     input logic [2:0] md, input logic [1:0] sel);
    valid_in = v; rs_val = a; rt_val = rt; ext_imm = imm;
    alu_src = src; alu_op = op; md_op = md; res_sel = sel;
  endtask

  // One clock cycle: check stall against the model, advance the model, check outputs.
  task automatic step();
    logic        exp_stall, acc, mbusy;
    logic [31:0] b;
    longint      sa, sb, q, r;
    logic [63:0] up;
    #1;
    mbusy     = (m_rem != 0);
    exp_stall = valid_in && mbusy && (md_op != 0 || res_sel == 1 || res_sel == 2);
    check("stall_out", stall_out, exp_stall);
    obs_stall = stall_out;
    acc = valid_in && !exp_stall;
    b   = alu_src ? ext_imm : rt_val;
    if (acc) begin
      m_res = (res_sel == 1) ? m_hi : (res_sel == 2) ? m_lo : ref_alu(alu_op, rs_val, b);
      m_rv  = 1;
    end else begin
      m_rv = 0;
    end
    if (m_rem == 1) begin
      m_hi = m_phi; m_lo = m_plo; m_rem = 0;
    end else if (m_rem > 1) begin
      m_rem--;
    end
    if (acc && !mbusy) begin
      if (md_op == 1 || md_op == 3) begin
        sa = longint'(int'(rs_val)); sb = longint'(int'(b));
      end else begin
        sa = longint'({32'd0, rs_val}); sb = longint'({32'd0, b});
      end
      case (md_op)
        3'd1: begin q = sa * sb; {m_phi, m_plo} = q; m_rem = MULT_N; end
        3'd2: begin up = {32'd0, rs_val} * {32'd0, b}; {m_phi, m_plo} = up; m_rem = MULT_N; end
        3'd3, 3'd4: if (b != 0) begin
          q = sa / sb; r = sa % sb;
          m_plo = q[31:0]; m_phi = r[31:0]; m_rem = DIV_N;
        end
        3'd5: m_hi = rs_val;
        3'd6: m_lo = rs_val;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    check("res_valid", res_valid, m_rv);
    check("res_out", res_out, m_res);
    check("busy", busy, (m_rem != 0));
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 32'($urandom_range(0, 3));
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cnt;
    int r;
    model_reset();
    obs_stall = 0;
    reset_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check("rst_res_out", res_out, 32'd0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // ADD with sign-extended immediate, then idle cycle drops res_valid
    drv(1, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 4'd0, 3'd0, 2'd0);
    step();
    check("add_res", res_out, 32'd4);
    check("add_valid", res_valid, 1'b1);
    idle();
    check("idle_valid", res_valid, 1'b0);

    // SLT / SLTU / SRA
    drv(1, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 4'd6, 3'd0, 2'd0); step();
    check("slt", res_out, 32'd1);
    drv(1, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 4'd7, 3'd0, 2'd0); step();
    check("sltu", res_out, 32'd0);
    drv(1, 32'd4, 32'h8000_0000, 32'd0, 0, 4'd10, 3'd0, 2'd0); step();
    check("sra", res_out, 32'hF800_0000);

    // mult: busy for exactly MULT_N cycles
    drv(1, 32'hFFFF_FFFE, 32'd3, 32'd0, 0, 4'd0, 3'd1, 2'd0); step();
    cnt = 0;
    for (int i = 0; i < 20 && busy; i++) begin cnt++; idle(); end
    check("mult_busy_len", cnt, MULT_N);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    drv(1, 32'hFFFF_FFFE, 32'd3, 32'd0, 0, 4'd0, 3'd2, 2'd0); step();
    for (int i = 0; i < 20 && busy; i++) idle();
    check("multu_hi", hi, 32'd2);
    check("multu_lo", lo, 32'hFFFF_FFFA);

    // div -7/2 followed immediately by mflo
    drv(1, 32'hFFFF_FFF9, 32'd2, 32'd0, 0, 4'd0, 3'd3, 2'd0); step();
    drv(1, 32'd0, 32'd0, 32'd0, 0, 4'd0, 3'd0, 2'd2);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (!obs_stall) break;
      cnt++;
    end
    check("div_stall_len", cnt, DIV_N);
    check("mflo", res_out, 32'hFFFF_FFFD);
    drv(1, 32'd0, 32'd0, 32'd0, 0, 4'd0, 3'd0, 2'd1); step();
    check("mfhi", res_out, 32'hFFFF_FFFF);

    // INT_MIN / -1
    drv(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 4'd0, 3'd3, 2'd0); step();
    for (int i = 0; i < 20 && busy; i++) idle();
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'd0);

    // divide by zero leaves preloaded HI/LO alone
    drv(1, 32'h1234_5678, 32'd0, 32'd0, 0, 4'd0, 3'd5, 2'd0); step();
    drv(1, 32'h1234_5678, 32'd0, 32'd0, 0, 4'd0, 3'd6, 2'd0); step();
    drv(1, 32'd99, 32'd0, 32'd0, 0, 4'd0, 3'd4, 2'd0); step();
    check("divz_busy", busy, 1'b0);
    check("divz_hi", hi, 32'h1234_5678);
    check("divz_lo", lo, 32'h1234_5678);

    // ADD during a running mult is not stalled
    drv(1, 32'd6, 32'd7, 32'd0, 0, 4'd0, 3'd1, 2'd0); step();
    drv(1, 32'd10, 32'd20, 32'd0, 0, 4'd0, 3'd0, 2'd0); step();
    check("add_busy_nostall", obs_stall, 1'b0);
    check("add_busy_res", res_out, 32'd30);
    for (int i = 0; i < 20 && busy; i++) idle();
    check("mult_small_lo", lo, 32'd42);

    // reset asserted in cycle 3 of a divide
    drv(1, 32'd100, 32'd7, 32'd0, 0, 4'd0, 3'd4, 2'd0); step();
    idle(); idle();
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_valid", res_valid, 1'b0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    drv(1, 32'd9, 32'd0, 32'd11, 1, 4'd0, 3'd2, 2'd0); step();
    for (int i = 0; i < 20 && busy; i++) idle();
    check("post_rst_lo", lo, 32'd99);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 15));
      drv(($urandom_range(0, 3) != 0), rand_val(), rand_val(), rand_val(),
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          (r < 7) ? 3'(r) : 3'd0, 2'($urandom_range(0, 3)));
      step();
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
